mul_seq_ctrl: RTL and testbench
===============================

# mul_seq_ctrl

Hardware sequencer for the program-3 double-precision multiply job. On a start handshake it walks the 16 operand pairs held in byte-wide data memory, feeds each pair to the shared 16×16 signed multiplier, and writes each 32-bit product back to memory big-endian. It sits between the top-level start/done pins, the data-memory port and the multiplier, and owns both resources for the whole run.

## Interface
- N_PAIRS, 16: operand pairs per run
- OP_BASE, 0: byte address of first operand
- PROD_BASE, 64: byte address of first product
- MUL_TIMEOUT, 64: cycles allowed for each multiplier response
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; a high→low transition launches a run; high aborts or holds idle
- done  out  1  run complete; held until start goes high
- err  out  1  multiplier timeout flag; held until start goes high
- dm_addr  out  8  data-memory byte address
- dm_wr_en  out  1  write strobe for dm_addr
- dm_wr_data  out  8  write byte
- dm_rd_data  in  8  read byte, registered: valid one cycle after dm_addr is presented with dm_wr_en=0
- mul_go  out  1  one-cycle launch pulse to the multiplier
- mul_a, mul_b  out  16  signed operands, stable from mul_go until mul_done
- mul_done  in  1  one-cycle pulse; mul_p valid in that cycle
- mul_p  in  32  signed product

## Operation
- Memory layout: pair j has operand A = {mem[OP_BASE+4j], mem[OP_BASE+4j+1]} and operand B = {mem[OP_BASE+4j+2], mem[OP_BASE+4j+3]}. The product P = B×A is written with mem[PROD_BASE+4j] = P[31:24] through mem[PROD_BASE+4j+3] = P[7:0].
- States:
  - IDLE: wait for start sampled 1.
  - ARM: wait for start sampled 0.
  - RD: issue 4 read addresses.
  - LAUNCH: pulse mul_go.
  - WAIT: wait for mul_done.
  - WR: 4 byte writes.
  - FIN: done=1.
- Transitions:
  - IDLE→ARM when start=1.
  - ARM→RD when start=0; j is cleared.
  - After WR, if j<N_PAIRS-1, increment j and go to RD; otherwise go to FIN.
  - FIN→ARM when start=1.
- Abort: start=1 in any state RD..WR returns to ARM next cycle.
  - dm_wr_en and mul_go drop immediately.
  - Writes already issued stay in memory.
  - done stays 0.
- Timeout: if WAIT lasts MUL_TIMEOUT cycles without mul_done, err=1 and go to FIN. Products of pairs ≥ j are not written.
- mul_done outside WAIT is ignored. An mul_done arriving in the same cycle as an abort is ignored.
- Products are 32-bit two's complement with no saturation; the full range is exact (-32768×-32768 = 0x4000_0000).
- Reset values: done=0, err=0, dm_addr=0, dm_wr_en=0, dm_wr_data=0, mul_go=0, mul_a=0, mul_b=0; state=IDLE, j=0.
- Reset mid-run: same as the reset values above; the next run needs a fresh start high→low.
- Start already low on leaving reset: no run launches, because a high is required first.

## Timing
- Cycle 0 is the first cycle in which start samples 0 in ARM.
- Per pair, with t0 = first RD cycle of the pair and k = mul_done latency after mul_go (k ≥ 1):
  - dm_addr = base+0..3 in cycles t0..t0+3; bytes are captured in t0+1..t0+4.
  - mul_go is high in t0+5.
  - mul_done arrives in t0+5+k; P is captured there.
  - Writes occur in t0+6+k..t0+9+k, most-significant byte first.
  - The next pair's t0 is t0+10+k.
- The first pair starts at t0 = 1.
- done rises in the cycle after the last write, so run latency is 16·(10+k)+1 cycles (k=1 gives 177).
- done and err fall in the cycle after start samples 1.
- At most one memory access per cycle. dm_wr_en is only high in WR.

## Test plan
- Basic: 16 pairs including 3×(-7), 0×12345, 1×-1, with multiplier latency k=1 → all 16 products correct at bytes 64..127; done rises at cycle 177; exactly 64 write cycles.
- Extremes: pairs (-32768,-32768), (32767,-32768), (32767,32767) → 0x40000000, 0xC0008000, 0x3FFF0001 written big-endian.
- Variable latency: model k random in 1..20 per pair → all products correct; mul_a/mul_b stable while waiting; mul_go is exactly one pulse per pair.
- Abort: raise start during pair 5's WAIT → no writes after that point; done stays 0. A new high→low start then completes all 16 pairs correctly.
- Reset mid-run in WR, and reset with start held low → every output returns to its reset value next cycle; no run without a fresh start edge; spurious mul_done in IDLE is ignored.
- Timeout: multiplier never responds on pair 2 → err=1 and done=1 after MUL_TIMEOUT cycles; only pairs 0–1 are written; both flags clear when start goes high.

Source files
------------

// File: rtl/mul_seq_ctrl_if.sv
// Signal bundle between the multiply sequencer and the start/done pins,
// the byte-wide data memory and the shared 16x16 signed multiplier.
interface mul_seq_ctrl_if;
  logic        start;
  logic        done;
  logic        err;
  logic [7:0]  dm_addr;
  logic        dm_wr_en;
  logic [7:0]  dm_wr_data;
  logic [7:0]  dm_rd_data;
  logic        mul_go;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_done;
  logic [31:0] mul_p;

  modport master (
    input  start,
    output done,
    output err,
    output dm_addr,
    output dm_wr_en,
    output dm_wr_data,
    input  dm_rd_data,
    output mul_go,
    output mul_a,
    output mul_b,
    input  mul_done,
    input  mul_p
  );

  modport slave (
    output start,
    input  done,
    input  err,
    input  dm_addr,
    input  dm_wr_en,
    input  dm_wr_data,
    output dm_rd_data,
    input  mul_go,
    input  mul_a,
    input  mul_b,
    output mul_done,
    output mul_p
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the multiply job: reads N_PAIRS operand pairs from data memory,
// runs each through the shared multiplier and writes the products big-endian.
module mul_seq_ctrl #(
  parameter int unsigned N_PAIRS     = 16,
  parameter int unsigned OP_BASE     = 0,
  parameter int unsigned PROD_BASE   = 64,
  parameter int unsigned MUL_TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  mul_seq_ctrl_if.master bus
);

  localparam int unsigned JW = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
  localparam int unsigned TW = $clog2(MUL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RD,
    LAUNCH,
    WAIT,
    WR,
    FIN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [JW-1:0] j;
  logic [2:0]    sub;
  logic [TW-1:0] wcnt;
  logic [15:0]   op_a;
  logic [15:0]   op_b;
  logic [31:0]   prod;
  logic          err_q;

  logic          busy;
  logic          abort;
  logic          last_pair;
  logic          timeout;
  logic          take_p;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    busy      = (state == RD) || (state == LAUNCH) || (state == WAIT) || (state == WR);
    abort     = busy && bus.start;
    last_pair = (j == JW'(N_PAIRS - 1));
    timeout   = (wcnt == TW'(MUL_TIMEOUT - 1));
    take_p    = (state == WAIT) && bus.mul_done && !abort;

    state_nxt      = state;
    bus.done       = 1'b0;
    bus.err        = err_q;
    bus.dm_addr    = '0;
    bus.dm_wr_en   = 1'b0;
    bus.dm_wr_data = '0;
    bus.mul_go     = 1'b0;
    bus.mul_a      = op_a;
    bus.mul_b      = op_b;

    case (state)
      IDLE: if (bus.start) state_nxt = ARM;
      ARM:  if (!bus.start) state_nxt = RD;
      RD: begin
        // sub 0..3 present addresses; sub 4 only captures the last byte
        if (!sub[2]) bus.dm_addr = 8'(OP_BASE) + 8'({j, 2'b00}) + 8'(sub[1:0]);
        if (abort)         state_nxt = ARM;
        else if (sub == 3'd4) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        bus.mul_go = 1'b1;
        state_nxt  = abort ? ARM : WAIT;
      end
      WAIT: begin
        if (abort)             state_nxt = ARM;
        else if (bus.mul_done) state_nxt = WR;
        else if (timeout)      state_nxt = FIN;
      end
      WR: begin
        bus.dm_wr_en = 1'b1;
        bus.dm_addr  = 8'(PROD_BASE) + 8'({j, 2'b00}) + 8'(sub[1:0]);
        case (sub[1:0])
          2'd0:    bus.dm_wr_data = prod[31:24];
          2'd1:    bus.dm_wr_data = prod[23:16];
          2'd2:    bus.dm_wr_data = prod[15:8];
          default: bus.dm_wr_data = prod[7:0];
        endcase
        if (abort)              state_nxt = ARM;
        else if (sub == 3'd3) state_nxt = last_pair ? FIN : RD;
      end
      FIN: begin
        bus.done = 1'b1;
        if (bus.start) state_nxt = ARM;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      j     <= '0;
      sub   <= '0;
      wcnt  <= '0;
      op_a  <= '0;
      op_b  <= '0;
      prod  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_nxt != state)                 sub <= '0;
      else if ((state == RD) || (state == WR)) sub <= sub + 3'd1;

      if ((state == ARM) && !bus.start) j <= '0;
      else if ((state == WR) && (sub == 3'd3) && !abort && !last_pair) j <= j + JW'(1);

      if (state == WAIT) wcnt <= wcnt + TW'(1);
      else               wcnt <= '0;

      // registered memory: byte addressed at sub-1 arrives while sub is current
      if (state == RD) begin
        case (sub)
          3'd1:    op_a[15:8] <= bus.dm_rd_data;
          3'd2:    op_a[7:0]  <= bus.dm_rd_data;
          3'd3:    op_b[15:8] <= bus.dm_rd_data;
          3'd4:    op_b[7:0]  <= bus.dm_rd_data;
          default: ;
        endcase
      end

      if (take_p) prod <= bus.mul_p;

      if ((state == WAIT) && (state_nxt == FIN)) err_q <= 1'b1;
      else if ((state == FIN) && bus.start)      err_q <= 1'b0;
    end
  end

  assert property (@(posedge clk) disable iff (reset) bus.mul_go |=> !bus.mul_go);
  assert property (@(posedge clk) disable iff (reset) bus.dm_wr_en |-> !bus.mul_go);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: memory and multiplier models, expected
// product bytes queued at load time and matched against every write.
module tb_mul_seq_ctrl;
  localparam int unsigned N   = 16;
  localparam int unsigned TMO = 64;
  localparam int unsigned PB  = 64;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;

  mul_seq_ctrl_if bus();

  mul_seq_ctrl #(
    .N_PAIRS    (N),
    .OP_BASE    (0),
    .PROD_BASE  (PB),
    .MUL_TIMEOUT(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  wr_t        exp_q[$];
  logic [7:0] op_mem [256];
  logic [7:0] wr_mem [256];
  shortint    pa [N];
  shortint    pb [N];
  int n_checks = 0;
  int n_fail   = 0;
  int wr_total = 0;
  int go_total = 0;
  int hang_at  = -1;
  int lat_fix  = 1;
  bit lat_rand = 1'b0;
  int poke_req = 0;
  int poke_ack = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Data memory: registered read from the operand image, writes captured separately
  always @(posedge clk) begin
    bus.dm_rd_data <= op_mem[bus.dm_addr];
    if (bus.dm_wr_en) wr_mem[bus.dm_addr] <= bus.dm_wr_data;
  end

  // Write monitor
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.dm_wr_en === 1'b1) begin
        wr_total++;
        check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus.dm_addr), 32'(e.addr));
          check("wr_data", 32'(bus.dm_wr_data), 32'(e.data));
        end
      end
    end
  end

  // Multiplier model with configurable latency, hang and spurious-pulse injection
  initial begin
    logic [15:0] a;
    logic [15:0] b;
    int k;
    bus.mul_done = 1'b0;
    bus.mul_p    = '0;
    forever begin
      tick();
      if (poke_req != poke_ack) begin
        bus.mul_p    = 32'hDEAD_BEEF;
        bus.mul_done = 1'b1;
        tick();
        bus.mul_done = 1'b0;
        poke_ack     = poke_req;
      end
      if (bus.mul_go === 1'b1) begin
        go_total++;
        if (go_total != hang_at) begin
          a = bus.mul_a;
          b = bus.mul_b;
          k = lat_rand ? int'($urandom_range(20, 1)) : lat_fix;
          for (int i = 0; i < k; i++) begin
            tick();
            check("mul_a_stable", 32'(bus.mul_a), 32'(a));
            check("mul_b_stable", 32'(bus.mul_b), 32'(b));
            check("mul_go_single", 32'(bus.mul_go), 32'd0);
          end
          bus.mul_p    = int'($signed(b)) * int'($signed(a));
          bus.mul_done = 1'b1;
          tick();
          bus.mul_done = 1'b0;
        end
      end
    end
  end

  task automatic fill_random();
    for (int j = 0; j < N; j++) begin
      pa[j] = shortint'($urandom);
      pb[j] = shortint'($urandom);
    end
  endtask

  task automatic load_ops();
    for (int j = 0; j < N; j++) begin
      op_mem[4*j]   = pa[j][15:8];
      op_mem[4*j+1] = pa[j][7:0];
      op_mem[4*j+2] = pb[j][15:8];
      op_mem[4*j+3] = pb[j][7:0];
    end
  endtask

  task automatic push_exp(input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      int  p;
      wr_t e;
      p      = int'(pa[i/4]) * int'(pb[i/4]);
      e.addr = 8'(PB + i);
      e.data = 8'(p >>> (8 * (3 - (i % 4))));
      exp_q.push_back(e);
    end
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, input int limit, input string tag);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < limit) begin
      tick();
      cyc++;
    end
    check(tag, 32'(bus.done), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_done"},    32'(bus.done),       32'd0);
    check({tag, "_err"},     32'(bus.err),        32'd0);
    check({tag, "_addr"},    32'(bus.dm_addr),    32'd0);
    check({tag, "_wr_en"},   32'(bus.dm_wr_en),   32'd0);
    check({tag, "_wr_data"}, 32'(bus.dm_wr_data), 32'd0);
    check({tag, "_go"},      32'(bus.mul_go),     32'd0);
    check({tag, "_a"},       32'(bus.mul_a),      32'd0);
    check({tag, "_b"},       32'(bus.mul_b),      32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, w0, g0, g, lcyc, seen;
    reset     = 1'b1;
    bus.start = 1'b0;
    for (int i = 0; i < 256; i++) op_mem[i] = '0;
    repeat (3) tick();
    check_idle("rst");
    reset = 1'b0;

    // Start low out of reset: nothing may launch; spurious mul_done ignored
    repeat (30) tick();
    check("no_start_go", 32'(go_total), 32'd0);
    poke_req++;
    repeat (6) tick();
    check_idle("idle_spurious");

    // Basic run, k = 1
    fill_random();
    pa[0] = 3; pb[0] = -7;
    pa[1] = 0; pb[1] = 12345;
    pa[2] = 1; pb[2] = -1;
    load_ops();
    push_exp(64);
    lat_rand = 1'b0; lat_fix = 1;
    w0 = wr_total;
    start_run();
    wait_done(cyc, 2000, "basic_done");
    check("basic_latency", 32'(cyc), 32'd177);
    check("basic_writes", 32'(wr_total - w0), 32'd64);
    check("basic_err", 32'(bus.err), 32'd0);
    check("basic_q_empty", 32'(exp_q.size()), 32'd0);

    // Extremes with random latency
    fill_random();
    pa[0] = -32768; pb[0] = -32768;
    pa[1] = 32767;  pb[1] = -32768;
    pa[2] = 32767;  pb[2] = 32767;
    load_ops();
    push_exp(64);
    lat_rand = 1'b1;
    w0 = wr_total; g0 = go_total;
    start_run();
    wait_done(cyc, 4000, "rand_done");
    check("rand_writes", 32'(wr_total - w0), 32'd64);
    check("rand_go_count", 32'(go_total - g0), 32'd16);
    check("rand_q_empty", 32'(exp_q.size()), 32'd0);
    check("ext_neg_neg", {wr_mem[64], wr_mem[65], wr_mem[66], wr_mem[67]}, 32'h4000_0000);
    check("ext_max_min", {wr_mem[68], wr_mem[69], wr_mem[70], wr_mem[71]}, 32'hC000_8000);
    check("ext_max_max", {wr_mem[72], wr_mem[73], wr_mem[74], wr_mem[75]}, 32'h3FFF_0001);

    // Abort during pair 5's WAIT, then restart from ARM
    lat_rand = 1'b0; lat_fix = 10;
    fill_random();
    load_ops();
    push_exp(20);
    w0 = wr_total; g0 = go_total;
    start_run();
    g = 0; cyc = 0;
    while (g < 6 && cyc < 2000) begin
      tick();
      cyc++;
      if (bus.mul_go === 1'b1) g++;
    end
    check("abort_reached", 32'(g), 32'd6);
    tick();
    bus.start = 1'b1;
    repeat (30) tick();
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_writes", 32'(wr_total - w0), 32'd20);
    check("abort_q_empty", 32'(exp_q.size()), 32'd0);
    check("abort_go_count", 32'(go_total - g0), 32'd6);
    lat_fix = 1;
    push_exp(64);
    w0 = wr_total;
    bus.start = 1'b0;
    wait_done(cyc, 2000, "restart_done");
    check("restart_latency", 32'(cyc), 32'd177);
    check("restart_writes", 32'(wr_total - w0), 32'd64);

    // Multiplier never answers pair 2
    fill_random();
    load_ops();
    push_exp(8);
    w0 = wr_total;
    hang_at = go_total + 3;
    start_run();
    g = 0; cyc = 0; lcyc = 0;
    while (bus.done !== 1'b1 && cyc < 3000) begin
      tick();
      cyc++;
      if (bus.mul_go === 1'b1) begin
        g++;
        if (g == 3) lcyc = cyc;
      end
    end
    check("tmo_done", 32'(bus.done), 32'd1);
    check("tmo_err", 32'(bus.err), 32'd1);
    check("tmo_delay", 32'(cyc - lcyc), 32'(TMO + 1));
    check("tmo_writes", 32'(wr_total - w0), 32'd8);
    check("tmo_q_empty", 32'(exp_q.size()), 32'd0);
    bus.start = 1'b1;
    tick();
    check("tmo_done_clr", 32'(bus.done), 32'd0);
    check("tmo_err_clr", 32'(bus.err), 32'd0);
    hang_at = -1;

    // Reset in the middle of pair 3's write burst
    fill_random();
    load_ops();
    push_exp(14);
    start_run();
    seen = 0; cyc = 0;
    while (seen < 14 && cyc < 2000) begin
      tick();
      cyc++;
      if (bus.dm_wr_en === 1'b1) seen++;
    end
    check("rst_mid_reached", 32'(seen), 32'd14);
    reset = 1'b1;
    tick();
    check_idle("rst_mid");
    reset = 1'b0;
    g0 = go_total;
    repeat (30) tick();
    check("rst_mid_q_empty", 32'(exp_q.size()), 32'd0);
    check("rst_mid_no_go", 32'(go_total - g0), 32'd0);
    poke_req++;
    repeat (6) tick();
    check_idle("rst_spurious");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
